// File: rtl/wb_pkg.sv
// Shared constants and types for the writeback arbiter and its users.
package wb_pkg;

   localparam int SRC_ALU    = 0;
   localparam int SRC_MUL    = 1;
   localparam int SRC_LSU    = 2;
   localparam int WB_NUM_SRC = 3;
   localparam int XLEN       = 32;
   localparam int REG_IDX_W  = 5;

   // One result as carried on a writeback channel.
   typedef struct packed {
      logic [REG_IDX_W-1:0] rd;
      logic [XLEN-1:0]      data;
   } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester found
// searching upward from ptr, wrapping modulo N (N need not be a power of two).
module rr_arbiter
   import wb_pkg::*;
#(
   parameter int N = 3,
   localparam int PTR_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req,
   input  logic [PTR_W-1:0] ptr,
   output logic [N-1:0]     grant,
   output logic [PTR_W-1:0] grant_idx,
   output logic             grant_any
);

   // One extra bit so ptr+k can exceed N before the explicit wrap.
   logic [PTR_W:0] pos;

   // Rotating priority search; the first hit wins, later hits are ignored.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      grant_any = 1'b0;
      pos       = '0;
      for (int k = 0; k < N; k++) begin
         pos = {1'b0, ptr} + (PTR_W+1)'(k);
         if (pos >= (PTR_W+1)'(N)) begin
            pos = pos - (PTR_W+1)'(N);
         end
         if (!grant_any && req[pos[PTR_W-1:0]]) begin
            grant_any                 = 1'b1;
            grant[pos[PTR_W-1:0]]     = 1'b1;
            grant_idx                 = pos[PTR_W-1:0];
         end
      end
   end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: one-entry holder per execution unit, round-robin pick
// of one occupied holder per cycle, registered register-file write port.
module wb_arbiter
   import wb_pkg::*;
#(
   parameter int NUM_SRC = WB_NUM_SRC,
   parameter int DATA_W  = XLEN,
   parameter int RD_W    = REG_IDX_W
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      flush,
   input  logic [NUM_SRC-1:0]        src_valid,
   output logic [NUM_SRC-1:0]        src_ready,
   input  logic [NUM_SRC*DATA_W-1:0] src_data,
   input  logic [NUM_SRC*RD_W-1:0]   src_rd,
   output logic                      wb_valid,
   output logic                      wb_we,
   output logic [RD_W-1:0]           wb_rd,
   output logic [DATA_W-1:0]         wb_data,
   output logic [NUM_SRC-1:0]        wb_src
);

   localparam int PTR_W = $clog2(NUM_SRC);

   logic [NUM_SRC-1:0] hold_v_q, hold_v_d;
   logic [DATA_W-1:0]  hold_data_q [NUM_SRC];
   logic [DATA_W-1:0]  hold_data_d [NUM_SRC];
   logic [RD_W-1:0]    hold_rd_q   [NUM_SRC];
   logic [RD_W-1:0]    hold_rd_d   [NUM_SRC];
   logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;

   logic               wb_valid_q, wb_valid_d;
   logic               wb_we_q, wb_we_d;
   logic [RD_W-1:0]    wb_rd_q, wb_rd_d;
   logic [DATA_W-1:0]  wb_data_q, wb_data_d;
   logic [NUM_SRC-1:0] wb_src_q, wb_src_d;

   logic [NUM_SRC-1:0] grant;
   logic [PTR_W-1:0]   grant_idx;
   logic               grant_any;
   logic [NUM_SRC-1:0] accept;

   rr_arbiter #(.N(NUM_SRC)) u_rr (
      .req       (hold_v_q),
      .ptr       (rr_ptr_q),
      .grant     (grant),
      .grant_idx (grant_idx),
      .grant_any (grant_any)
   );

   // A granted holder drains this edge, so it may refill at the same time.
   // Flush deliberately does not gate ready; it only discards what arrives.
   assign src_ready = ~hold_v_q | grant;
   assign accept    = src_valid & src_ready & {NUM_SRC{~flush}};

   // Holder next state: load on accept, clear when drained, wipe on flush.
   always_comb begin
      hold_v_d = flush ? '0 : ((hold_v_q & ~grant) | accept);
      for (int i = 0; i < NUM_SRC; i++) begin
         hold_data_d[i] = accept[i] ? src_data[i*DATA_W +: DATA_W] : hold_data_q[i];
         hold_rd_d[i]   = accept[i] ? src_rd[i*RD_W +: RD_W]       : hold_rd_q[i];
      end
   end

   // Writeback slot and pointer update; data/rd keep old values when idle.
   always_comb begin
      wb_valid_d = 1'b0;
      wb_we_d    = 1'b0;
      wb_src_d   = '0;
      wb_rd_d    = wb_rd_q;
      wb_data_d  = wb_data_q;
      rr_ptr_d   = rr_ptr_q;
      if (!flush && grant_any) begin
         wb_valid_d = 1'b1;
         wb_rd_d    = hold_rd_q[grant_idx];
         wb_data_d  = hold_data_q[grant_idx];
         wb_we_d    = (hold_rd_q[grant_idx] != '0);
         wb_src_d   = grant;
         rr_ptr_d   = (grant_idx == PTR_W'(NUM_SRC-1)) ? '0 : grant_idx + 1'b1;
      end
   end

   // State registers with asynchronous clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_v_q   <= '0;
         rr_ptr_q   <= '0;
         wb_valid_q <= 1'b0;
         wb_we_q    <= 1'b0;
         wb_rd_q    <= '0;
         wb_data_q  <= '0;
         wb_src_q   <= '0;
         for (int i = 0; i < NUM_SRC; i++) begin
            hold_data_q[i] <= '0;
            hold_rd_q[i]   <= '0;
         end
      end else begin
         hold_v_q   <= hold_v_d;
         rr_ptr_q   <= rr_ptr_d;
         wb_valid_q <= wb_valid_d;
         wb_we_q    <= wb_we_d;
         wb_rd_q    <= wb_rd_d;
         wb_data_q  <= wb_data_d;
         wb_src_q   <= wb_src_d;
         for (int i = 0; i < NUM_SRC; i++) begin
            hold_data_q[i] <= hold_data_d[i];
            hold_rd_q[i]   <= hold_rd_d[i];
         end
      end
   end

   assign wb_valid = wb_valid_q;
   assign wb_we    = wb_we_q;
   assign wb_rd    = wb_rd_q;
   assign wb_data  = wb_data_q;
   assign wb_src   = wb_src_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter with three sources (ALU, MUL, LSU).
module tb_wb_arbiter;

   localparam int NS = 3;
   localparam int DW = 32;
   localparam int RW = 5;

   logic             clk;
   logic             rst;
   logic             flush;
   logic [NS-1:0]    src_valid;
   logic [NS-1:0]    src_ready;
   logic [NS*DW-1:0] src_data;
   logic [NS*RW-1:0] src_rd;
   logic             wb_valid;
   logic             wb_we;
   logic [RW-1:0]    wb_rd;
   logic [DW-1:0]    wb_data;
   logic [NS-1:0]    wb_src;

   int n_checks = 0;
   int n_fail   = 0;

   logic [NS-1:0] exp_src;
   logic [DW-1:0] exp_data;

   wb_arbiter #(.NUM_SRC(NS), .DATA_W(DW), .RD_W(RW)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .src_valid (src_valid),
      .src_ready (src_ready),
      .src_data  (src_data),
      .src_rd    (src_rd),
      .wb_valid  (wb_valid),
      .wb_we     (wb_we),
      .wb_rd     (wb_rd),
      .wb_data   (wb_data),
      .wb_src    (wb_src)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_src(input int i, input logic [RW-1:0] rd, input logic [DW-1:0] data);
      src_rd[i*RW +: RW]   = rd;
      src_data[i*DW +: DW] = data;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
      $display("check %-16s observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   initial begin
      rst       = 1'b1;
      flush     = 1'b0;
      src_valid = '0;
      src_data  = '0;
      src_rd    = '0;

      // ---- reset state ----
      tick();
      tick();
      chk("rst_wb_valid", wb_valid, 1'b0);
      chk("rst_wb_src",   wb_src,   3'b000);
      rst = 1'b0;
      #1;
      chk("rst_ready", src_ready, 3'b111);

      // ---- fill all holders, then reset mid-stream ----
      set_src(0, 5'd1, 32'hAAAA_0000);
      set_src(1, 5'd2, 32'hBBBB_0000);
      set_src(2, 5'd3, 32'hCCCC_0000);
      src_valid = 3'b111;
      tick();
      src_valid = 3'b000;
      chk("full_ready", src_ready, 3'b001);
      #2 rst = 1'b1;
      #1;
      chk("async_wb_valid", wb_valid, 1'b0);
      chk("async_ready",    src_ready, 3'b111);
      rst = 1'b0;
      #1;
      chk("post_rst_ready", src_ready, 3'b111);
      chk("post_rst_valid", wb_valid, 1'b0);
      tick();
      chk("no_stale_wb", wb_valid, 1'b0);

      // ---- single ALU result, one-cycle latency ----
      set_src(0, 5'd5, 32'hDEAD_BEEF);
      src_valid = 3'b001;
      tick();
      src_valid = 3'b000;
      chk("alu_lat_n", wb_valid, 1'b0);
      tick();
      chk("alu_valid", wb_valid, 1'b1);
      chk("alu_we",    wb_we,    1'b1);
      chk("alu_rd",    wb_rd,    5'd5);
      chk("alu_data",  wb_data,  32'hDEAD_BEEF);
      chk("alu_src",   wb_src,   3'b001);
      tick();
      chk("alu_idle", wb_valid, 1'b0);
      chk("alu_idle_src", wb_src, 3'b000);

      // ---- MUL streaming for 8 cycles ----
      for (int k = 0; k < 10; k++) begin
         if (k < 8) begin
            set_src(1, 5'(k + 1), 32'h100 + 32'(k));
            src_valid = 3'b010;
         end else begin
            src_valid = 3'b000;
         end
         tick();
         chk("stream_ready1", src_ready[1], 1'b1);
         chk("stream_valid", wb_valid, (k >= 1 && k <= 8) ? 1'b1 : 1'b0);
         if (k >= 1 && k <= 8) begin
            exp_data = 32'h100 + 32'(k - 1);
            chk("stream_data", wb_data, exp_data);
            chk("stream_src",  wb_src,  3'b010);
         end
      end

      // ---- LSU write to x0 ----
      set_src(2, 5'd0, 32'h0000_1234);
      src_valid = 3'b100;
      tick();
      src_valid = 3'b000;
      tick();
      chk("x0_valid", wb_valid, 1'b1);
      chk("x0_we",    wb_we,    1'b0);
      chk("x0_src",   wb_src,   3'b100);
      chk("x0_data",  wb_data,  32'h0000_1234);

      // ---- three-way contention ----
      set_src(0, 5'd1, 32'h11);
      set_src(1, 5'd2, 32'h22);
      set_src(2, 5'd3, 32'h33);
      src_valid = 3'b111;
      tick();
      src_valid = 3'b000;
      chk("cont_ready_a", src_ready, 3'b001);
      chk("cont_valid_a", wb_valid,  1'b0);
      tick();
      chk("cont_data_0",  wb_data,   32'h11);
      chk("cont_src_0",   wb_src,    3'b001);
      chk("cont_ready_b", src_ready, 3'b011);
      tick();
      chk("cont_data_1",  wb_data,   32'h22);
      chk("cont_src_1",   wb_src,    3'b010);
      chk("cont_ready_c", src_ready, 3'b111);
      tick();
      chk("cont_data_2",  wb_data,   32'h33);
      chk("cont_src_2",   wb_src,    3'b100);
      chk("cont_rd_2",    wb_rd,     5'd3);
      tick();
      chk("cont_idle",    wb_valid,  1'b0);

      // ---- round-robin fairness: ALU and LSU continuously valid ----
      set_src(0, 5'd4, 32'h0000_AAAA);
      set_src(2, 5'd6, 32'h0000_5555);
      for (int k = 0; k < 9; k++) begin
         src_valid = (k < 6) ? 3'b101 : 3'b000;
         tick();
         if (k == 0 || k == 8) begin
            chk("rr_idle", wb_valid, 1'b0);
         end else begin
            exp_src  = (k % 2 == 1) ? 3'b001 : 3'b100;
            exp_data = (k % 2 == 1) ? 32'h0000_AAAA : 32'h0000_5555;
            chk("rr_src",  wb_src,  exp_src);
            chk("rr_data", wb_data, exp_data);
         end
      end
      src_valid = 3'b000;

      // ---- flush with two held results plus a new ALU input ----
      set_src(1, 5'd7, 32'h77);
      set_src(2, 5'd8, 32'h88);
      src_valid = 3'b110;
      tick();
      set_src(0, 5'd9, 32'h99);
      src_valid = 3'b001;
      flush     = 1'b1;
      #1;
      chk("flush_ready", src_ready, 3'b011);
      tick();
      flush     = 1'b0;
      src_valid = 3'b000;
      chk("flush_valid", wb_valid,  1'b0);
      chk("flush_we",    wb_we,     1'b0);
      chk("flush_src",   wb_src,    3'b000);
      chk("flush_ready2", src_ready, 3'b111);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("flush_quiet", wb_valid, 1'b0);
      end
      set_src(0, 5'd10, 32'h0000_0ABC);
      src_valid = 3'b001;
      tick();
      src_valid = 3'b000;
      tick();
      chk("post_flush_valid", wb_valid, 1'b1);
      chk("post_flush_data",  wb_data,  32'h0000_0ABC);
      chk("post_flush_rd",    wb_rd,    5'd10);
      chk("post_flush_src",   wb_src,   3'b001);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
